// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_mux_arbiter_pkg                                               |
// | Purpose : Shared constants, state encoding and helpers for the round-robin |
// |           mux arbiter.                                                     |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package rr_mux_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Index to one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_priority_pick                                                 |
// | Purpose : Combinational round-robin pick: first set request at or above    |
// |           ptr, wrapping modulo NREQ.                                       |
// | Ports   : req [3:0]  in   request vector                                   |
// |           ptr [1:0]  in   index where the scan starts                      |
// |           any        out  at least one request set                         |
// |           win [1:0]  out  winning index (valid only when any=1)            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_priority_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [SEL_W-1:0]  off;

  always_comb begin
    // Rotate so bit 0 of req_rot is req[ptr]; the doubled copy handles the wrap.
    req_dbl = {req, req};
    req_rot = req_dbl[{1'b0, ptr} +: NREQ];

    // Lowest set bit of the rotated vector is the offset from ptr.
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = SEL_W'(i);
      end
    end

    // Un-rotate: the 2-bit add wraps modulo NREQ for free.
    win = ptr + off;
    any = |req;
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_mux_arbiter                                                   |
// | Purpose : Round-robin arbiter sharing a 4:1 data mux among four sources,   |
// |           with each tenure capped at QUANTUM cycles.                       |
// | Ports   : clk            in   rising-edge clock                            |
// |           rst_n          in   asynchronous active-low reset                |
// |           req   [3:0]    in   level-sensitive requests                     |
// |           data  [4*DW-1] in   source i at data[i*DW +: DW]                 |
// |           grant [3:0]    out  registered one-hot grant                     |
// |           sel   [1:0]    out  registered index of the owner                |
// |           valid          out  grant is non-zero                            |
// |           z     [DW-1:0] out  owner's data, 0 when idle                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int QUANTUM = 4,
  parameter int DW      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    grant,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic [DW-1:0]      z
);

  localparam int               CNT_W    = $clog2(QUANTUM) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             owner_req;
  logic             expire;

  // While an owner holds the grant, a release re-picks from owner+1 in the
  // same edge; ptr_q is only updated alongside, so it cannot be used here.
  assign pick_ptr  = (state_q == ST_GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;
  assign owner_req = req[sel_q];
  assign expire    = (cnt_q == CNT_LAST);

  rr_priority_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (any),
    .win (win)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_GRANT;
          grant_d = onehot(win);
          sel_d   = win;
          cnt_d   = '0;
        end
      end

      ST_GRANT: begin
        if (owner_req && !expire) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Release. The owner is scanned last, so it only wins again when
          // it is the sole remaining requester.
          ptr_d = sel_q + SEL_W'(1);
          cnt_d = '0;
          if (any) begin
            grant_d = onehot(win);
            sel_d   = win;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            sel_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = |grant_q;

  always_comb begin
    z = '0;
    if (valid) begin
      case (sel_q)
        2'd0: z = data[0*DW +: DW];
        2'd1: z = data[1*DW +: DW];
        2'd2: z = data[2*DW +: DW];
        2'd3: z = data[3*DW +: DW];
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_rr_mux_arbiter                                                |
// | Purpose : Directed scoreboard bench for rr_mux_arbiter (QUANTUM=4, DW=4).  |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_rr_mux_arbiter;

  localparam int QUANTUM = 4;
  localparam int DW      = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req   = '0;
  logic [4*DW-1:0] data  = '0;
  logic [3:0]      grant;
  logic [1:0]      sel;
  logic            valid;
  logic [DW-1:0]   z;

  rr_mux_arbiter #(.QUANTUM(QUANTUM), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .data  (data),
    .grant (grant),
    .sel   (sel),
    .valid (valid),
    .z     (z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    g;
    logic [DW-1:0] z;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] slot(input logic [4*DW-1:0] d, input logic [3:0] g);
    if (g == 4'b0000) return '0;
    return d[enc(g)*DW +: DW];
  endfunction

  // Monitor: one expectation per cycle, popped just after the clock edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_known", 32'($isunknown(req)), 32'd0);
        chk("grant", 32'(grant), 32'(e.g));
        chk("sel", 32'(sel), 32'(enc(e.g)));
        chk("valid", 32'(valid), 32'(e.g != 4'b0000));
        chk("z", 32'(z), 32'(e.z));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
      end
    end
  end

  // Drive req/data for one cycle; g is the grant expected after the next edge.
  task automatic step(input logic [3:0] r, input logic [4*DW-1:0] d, input logic [3:0] g);
    exp_t e;
    @(negedge clk);
    req  = r;
    data = d;
    e.g  = g;
    e.z  = slot(d, g);
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data  = 16'h4321;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    // Power-on reset.
    data = 16'h4321;
    #2;
    chk("por_grant", 32'(grant), 32'd0);
    chk("por_valid", 32'(valid), 32'd0);
    chk("por_z", 32'(z), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 2; z follows the data of slot 2; drop -> idle.
    step(4'b0100, 16'hA5C3, 4'b0100);
    step(4'b0100, 16'h0900, 4'b0100);
    step(4'b0000, 16'hFFFF, 4'b0000);
    step(4'b0000, 16'hFFFF, 4'b0000);

    // All four request: 4-cycle tenures 0,1,2,3,0 without gaps.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 16'h4321, 4'b0001 << ((i / 4) % 4));
    end
    step(4'b0000, 16'h4321, 4'b0000);   // ptr -> 1

    // Owner 1 drops after 2 cycles with req[3] pending.
    step(4'b1010, 16'h4321, 4'b0010);
    step(4'b1010, 16'h4321, 4'b0010);
    step(4'b1000, 16'h4321, 4'b1000);
    step(4'b1000, 16'h8765, 4'b1000);
    step(4'b0000, 16'h4321, 4'b0000);   // ptr -> 0

    // Sole requester 0 held 10 cycles: re-granted at each quantum.
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 16'h4329 + 16'(i), 4'b0001);
    end
    step(4'b0000, 16'h4321, 4'b0000);   // ptr -> 1

    // Reset mid-tenure of owner 3; first pick afterwards starts at 0.
    step(4'b1000, 16'h4321, 4'b1000);
    step(4'b1000, 16'h4321, 4'b1000);
    pulse_reset();
    step(4'b1010, 16'h4321, 4'b0010);
    step(4'b0000, 16'h4321, 4'b0000);   // ptr -> 2

    // Idle, then a new request is granted one clock later.
    step(4'b0000, 16'h4321, 4'b0000);
    step(4'b0001, 16'h4321, 4'b0001);
    step(4'b0000, 16'h4321, 4'b0000);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      chk("drain", 32'(exp_q.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
